ifetch_unit: RTL and testbench

Instruction fetch responder for the multi-cycle CPU. It serves the control FSM's fetch request (`write_ir`) by reading one 32-bit word from instruction memory at the current PC over a req/ack handshake. It holds the word in the instruction register `I` and reports completion on `W_IR_valid`. Misaligned PCs and memory timeouts return a fixed undefined-instruction word, so the decoder raises `Und_Ins` and the controller never stalls forever.

---
 rtl/ifetch_unit.sv | 120 ++++++++++++
 tb/tb_ifetch_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
//------------------------------------------------------------------------------
// ifetch_unit
//   Instruction fetch responder: on a write_ir request it reads one word from
//   instruction memory at pc over a req/ack handshake and loads it into I.
//   Misaligned pcs and memory timeouts load UND_WORD and flag fetch_err.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ifetch_unit #(
   parameter int          TIMEOUT  = 255,
   parameter logic [31:0] UND_WORD = 32'hE7F000F0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        write_ir,
   input  logic [31:0] pc,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic        im_ack,
   input  logic [31:0] im_rdata,
   output logic [31:0] I,
   output logic        W_IR_valid,
   output logic        fetch_err,
   output logic [1:0]  err_code,
   output logic        busy
);

   // Wait counter only needs to reach TIMEOUT-1; keep at least one bit so a
   // disabled timeout still yields a legal vector.
   localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   localparam logic [1:0] CODE_NONE      = 2'b00;
   localparam logic [1:0] CODE_MISALIGN  = 2'b01;
   localparam logic [1:0] CODE_TIMEOUT   = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ERR  = 2'd2
   } state_t;

   state_t        state;
   logic [TW-1:0] tcnt;
   logic [1:0]    pend_code;

   // Fetch FSM; every output is a register updated alongside the state so
   // nothing on the inputs reaches an output in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         tcnt       <= '0;
         pend_code  <= CODE_NONE;
         im_req     <= 1'b0;
         im_addr    <= 32'd0;
         I          <= 32'd0;
         W_IR_valid <= 1'b0;
         fetch_err  <= 1'b0;
         err_code   <= CODE_NONE;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (write_ir) begin
                  W_IR_valid <= 1'b0;
                  busy       <= 1'b1;
                  if (pc[1:0] == 2'b00) begin
                     im_addr   <= pc;
                     im_req    <= 1'b1;
                     tcnt      <= '0;
                     fetch_err <= 1'b0;
                     err_code  <= CODE_NONE;
                     state     <= REQ;
                  end else begin
                     // No memory access for a misaligned pc.
                     pend_code <= CODE_MISALIGN;
                     state     <= ERR;
                  end
               end
            end

            REQ: begin
               if (im_ack) begin
                  I          <= im_rdata;
                  W_IR_valid <= 1'b1;
                  tcnt       <= '0;
                  im_req     <= 1'b0;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end else if ((TIMEOUT != 0) && (tcnt == TLAST)) begin
                  pend_code <= CODE_TIMEOUT;
                  im_req    <= 1'b0;
                  state     <= ERR;
               end else if (TIMEOUT != 0) begin
                  tcnt <= tcnt + 1'b1;
               end
            end

            ERR: begin
               I          <= UND_WORD;
               W_IR_valid <= 1'b1;
               fetch_err  <= 1'b1;
               err_code   <= pend_code;
               busy       <= 1'b0;
               state      <= IDLE;
            end

            default: begin
               im_req <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
//------------------------------------------------------------------------------
// tb_ifetch_unit
//   Self-checking bench for ifetch_unit with TIMEOUT=4. A memory responder
//   acks after a chosen number of request cycles; the expected word, error
//   code and completion latency are computed from the fetch rules directly.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ifetch_unit;

   localparam int          TO  = 4;
   localparam logic [31:0] UND = 32'hE7F000F0;

   logic        clk = 1'b0;
   logic        rst;
   logic        write_ir;
   logic [31:0] pc;
   logic        im_req;
   logic [31:0] im_addr;
   logic        im_ack;
   logic [31:0] im_rdata;
   logic [31:0] I;
   logic        W_IR_valid;
   logic        fetch_err;
   logic [1:0]  err_code;
   logic        busy;

   int checks = 0;
   int errors = 0;

   ifetch_unit #(.TIMEOUT(TO), .UND_WORD(UND)) dut (
      .clk        (clk),
      .rst        (rst),
      .write_ir   (write_ir),
      .pc         (pc),
      .im_req     (im_req),
      .im_addr    (im_addr),
      .im_ack     (im_ack),
      .im_rdata   (im_rdata),
      .I          (I),
      .W_IR_valid (W_IR_valid),
      .fetch_err  (fetch_err),
      .err_code   (err_code),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One fetch. lat = REQ cycle in which memory acks (0 = never acks).
   // hold keeps write_ir high through the first post-request cycle.
   task automatic do_fetch(input logic [31:0] p, input logic [31:0] d,
                           input int lat, input bit hold);
      logic [31:0] exp_i;
      logic [1:0]  exp_code;
      int          exp_lat, exp_req, cyc, nreq, bad_addr;
      // Reference outcome from the fetch rules.
      if (p[1:0] != 2'b00) begin
         exp_i = UND; exp_code = 2'b01; exp_lat = 2;       exp_req = 0;
      end else if (lat >= 1 && lat <= TO) begin
         exp_i = d;   exp_code = 2'b00; exp_lat = lat + 1; exp_req = lat;
      end else begin
         exp_i = UND; exp_code = 2'b10; exp_lat = TO + 2;  exp_req = TO;
      end

      @(negedge clk);
      write_ir = 1'b1;
      pc       = p;
      @(negedge clk);
      write_ir = hold;
      cyc      = 1;
      nreq     = 0;
      bad_addr = 0;
      chk("valid_drop", {31'd0, W_IR_valid}, 32'd0);
      chk("busy_start", {31'd0, busy}, 32'd1);
      while (!W_IR_valid && cyc < 40) begin
         if (im_req) begin
            nreq++;
            if (im_addr !== p) bad_addr++;
            if (nreq == lat) begin
               im_ack   = 1'b1;
               im_rdata = d;
            end
         end
         @(negedge clk);
         im_ack   = 1'b0;
         im_rdata = $urandom;
         write_ir = 1'b0;
         cyc++;
      end
      chk("latency",   cyc,                   exp_lat);
      chk("req_count", nreq,                  exp_req);
      chk("addr_hold", bad_addr,              0);
      chk("I",         I,                     exp_i);
      chk("fetch_err", {31'd0, fetch_err},    {31'd0, (exp_code != 2'b00)});
      chk("err_code",  {30'd0, err_code},     {30'd0, exp_code});
      chk("busy_end",  {31'd0, busy},         32'd0);

      // A late ack after a timeout must be ignored.
      if (exp_code == 2'b10) begin
         im_ack   = 1'b1;
         im_rdata = ~d;
         @(negedge clk);
         im_ack = 1'b0;
         chk("late_ack_I",     I,                  UND);
         chk("late_ack_valid", {31'd0, W_IR_valid}, 32'd1);
         chk("late_ack_req",   {31'd0, im_req},    32'd0);
         chk("late_ack_busy",  {31'd0, busy},      32'd0);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_I"},     I,                     32'd0);
      chk({tag, "_valid"}, {31'd0, W_IR_valid},   32'd0);
      chk({tag, "_err"},   {31'd0, fetch_err},    32'd0);
      chk({tag, "_code"},  {30'd0, err_code},     32'd0);
      chk({tag, "_req"},   {31'd0, im_req},       32'd0);
      chk({tag, "_addr"},  im_addr,               32'd0);
      chk({tag, "_busy"},  {31'd0, busy},         32'd0);
   endtask

   // Directed sequence followed by randomized fetches.
   initial begin
      logic [31:0] rp;
      int          rl;
      rst      = 1'b1;
      write_ir = 1'b0;
      pc       = 32'd0;
      im_ack   = 1'b0;
      im_rdata = 32'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Idle after reset: no request ever.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_req", {31'd0, im_req}, 32'd0);
      end
      chk_reset_vals("reset");

      // Normal fetch, ack in the third REQ cycle.
      do_fetch(32'h0000_0100, 32'hE081_1002, 3, 1'b0);

      // Back-to-back zero-wait fetches with write_ir held into REQ.
      for (int i = 0; i < 3; i++)
         do_fetch(32'h0000_0200 + 32'(i * 4), $urandom, 1, 1'b1);

      // Misaligned.
      do_fetch(32'h0000_0102, 32'h1234_5678, 1, 1'b0);

      // Timeout, memory never acks.
      do_fetch(32'h0000_0300, 32'hCAFE_F00D, 0, 1'b0);

      // Reset in the second REQ cycle with a simultaneous ack.
      @(negedge clk);
      write_ir = 1'b1;
      pc       = 32'h0000_0400;
      @(negedge clk);
      write_ir = 1'b0;
      @(negedge clk);
      rst      = 1'b1;
      im_ack   = 1'b1;
      im_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      rst    = 1'b0;
      im_ack = 1'b0;
      chk_reset_vals("rst_in_req");
      do_fetch(32'h0000_0404, 32'h0BAD_F00D, 2, 1'b0);

      // Randomized fetches: mixed alignment and ack latency 0..6.
      for (int i = 0; i < 30; i++) begin
         rp = $urandom;
         if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
         rl = int'($urandom_range(0, 6));
         do_fetch(rp, $urandom, rl, 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
